// File: rtl/prm_oblgc_scan_pkg.sv
// Shared types and sizing for the programmable obstacle-logic term scanner.
package prm_oblgc_pkg;

   localparam int unsigned IN_W      = 15;
   localparam int unsigned NUM_TERMS = 256;
   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned TA_W      = $clog2(NUM_TERMS);
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W     = TA_W + 1;

   localparam logic [NUM_CH-1:0] MASK_ALL = '1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   typedef struct packed {
      logic [IN_W-1:0] care;
      logic [IN_W-1:0] val;
      logic [CH_W-1:0] ch;
   } term_t;

endpackage

// File: rtl/prm_oblgc_scan_if.sv
// Config, query and result handshakes between sampler, scanner and pruner.
interface prm_oblgc_scan_if
   import prm_oblgc_pkg::*;
   ;

   logic              cfg_we;
   logic [TA_W-1:0]   cfg_addr;
   logic [IN_W-1:0]   cfg_care;
   logic [IN_W-1:0]   cfg_val;
   logic [CH_W-1:0]   cfg_ch;
   logic              cfg_cnt_we;
   logic [CNT_W-1:0]  cfg_cnt;
   logic              cfg_ready;
   logic              q_valid;
   logic [IN_W-1:0]   q_data;
   logic              q_ready;
   logic              res_valid;
   logic [NUM_CH-1:0] res_mask;
   logic              res_ready;

   modport master (
      output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_ch, cfg_cnt_we, cfg_cnt,
      output q_valid, q_data, res_ready,
      input  cfg_ready, q_ready, res_valid, res_mask
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_ch, cfg_cnt_we, cfg_cnt,
      input  q_valid, q_data, res_ready,
      output cfg_ready, q_ready, res_valid, res_mask
   );

endinterface

// File: rtl/prm_oblgc_scan_term_match.sv
// Combinational cube match: hit when every cared-for bit equals its literal polarity.
module prm_oblgc_term_match
   import prm_oblgc_pkg::*;
(
   input  logic [IN_W-1:0] query_i,
   input  logic [IN_W-1:0] care_i,
   input  logic [IN_W-1:0] val_i,
   output logic            hit_o
);

   assign hit_o = ~|((query_i ^ val_i) & care_i);

endmodule

// File: rtl/prm_oblgc_scan.sv
// Sequential sum-of-products scanner: one term per cycle, per-channel OR into edge_mask.
module prm_oblgc_scan
   import prm_oblgc_pkg::*;
(
   input  logic             CLK,
   input  logic             RSTn,
   prm_oblgc_scan_if.slave  bus
);

   state_t            state_q, state_d;
   logic [TA_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IN_W-1:0]   query_q, query_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic              q_ready_q, q_ready_d;
   logic              cfg_ready_q, cfg_ready_d;
   logic              res_valid_q, res_valid_d;

   term_t             tbl_q [NUM_TERMS];
   term_t             cur_term;
   term_t             wr_term;
   logic              tbl_we;
   logic              hit;
   logic [NUM_CH-1:0] hit_vec;
   logic [CNT_W-1:0]  cnt_sat;
   logic              scan_last;

   prm_oblgc_term_match u_match (
      .query_i (query_q),
      .care_i  (cur_term.care),
      .val_i   (cur_term.val),
      .hit_o   (hit)
   );

   assign cur_term  = tbl_q[idx_q];
   assign wr_term   = '{care: bus.cfg_care, val: bus.cfg_val, ch: bus.cfg_ch};
   assign cnt_sat   = (bus.cfg_cnt > CNT_W'(NUM_TERMS)) ? CNT_W'(NUM_TERMS) : bus.cfg_cnt;
   assign scan_last = ({1'b0, idx_q} == (cnt_q - CNT_W'(1)));

   // Channel select; out-of-range channel codes never match a mask bit.
   always_comb begin
      hit_vec = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (hit && (cur_term.ch == CH_W'(c))) hit_vec[c] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         query_q     <= '0;
         mask_q      <= '0;
         q_ready_q   <= 1'b1;
         cfg_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         query_q     <= query_d;
         mask_q      <= mask_d;
         q_ready_q   <= q_ready_d;
         cfg_ready_q <= cfg_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int unsigned i = 0; i < NUM_TERMS; i++) tbl_q[i] <= '0;
      end else if (tbl_we) begin
         tbl_q[bus.cfg_addr] <= wr_term;
      end
   end

   // Next state; the term-count check on accept sees a same-cycle count write.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      query_d = query_q;
      mask_d  = mask_q;
      tbl_we  = 1'b0;

      case (state_q)
         IDLE: begin
            tbl_we = bus.cfg_we;
            if (bus.cfg_cnt_we) cnt_d = cnt_sat;
            if (bus.q_valid) begin
               query_d = bus.q_data;
               mask_d  = '0;
               idx_d   = '0;
               state_d = (cnt_d == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            mask_d = mask_q | hit_vec;
            if (scan_last || (mask_d == MASK_ALL)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + TA_W'(1);
            end
         end
         DONE: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      q_ready_d   = (state_d == IDLE);
      cfg_ready_d = (state_d == IDLE);
      res_valid_d = (state_d == DONE);
   end

   assign bus.q_ready   = q_ready_q;
   assign bus.cfg_ready = cfg_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_mask  = mask_q;

endmodule

// File: tb/tb_prm_oblgc_scan.sv
// Scoreboard bench for prm_oblgc_scan: reference term model predicts mask and latency.
module tb_prm_oblgc_scan;
   import prm_oblgc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   prm_oblgc_scan_if bus ();

   prm_oblgc_scan dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [14:0] m_care [256];
   logic [14:0] m_val  [256];
   logic [1:0]  m_ch   [256];
   int          m_cnt;

   logic [3:0]  exp_mask_q [$];
   int          exp_k_q    [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_eval(input logic [14:0] d, output logic [3:0] m, output int k);
      m = '0;
      k = 0;
      for (int i = 0; i < m_cnt; i++) begin
         k++;
         if (((d ^ m_val[i]) & m_care[i]) == '0) m[m_ch[i]] = 1'b1;
         if (m == 4'hF) break;
      end
   endfunction

   function automatic logic g50(input logic [14:0] q);
      return !q[14] & q[13] & q[12] & q[11] & q[9] & !q[8] & !q[7] & !q[4];
   endfunction

   function automatic void model_reset();
      m_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         m_care[i] = '0;
         m_val[i]  = '0;
         m_ch[i]   = '0;
      end
   endfunction

   task automatic write_term(input int a, input logic [14:0] care, input logic [14:0] val,
                             input logic [1:0] ch);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 8'(a);
      bus.cfg_care = care;
      bus.cfg_val  = val;
      bus.cfg_ch   = ch;
      m_care[a] = care;
      m_val[a]  = val;
      m_ch[a]   = ch;
      @(posedge clk);
      #1 bus.cfg_we = 1'b0;
   endtask

   task automatic write_cnt(input int c);
      @(negedge clk);
      bus.cfg_cnt_we = 1'b1;
      bus.cfg_cnt    = 9'(c);
      m_cnt = (c > 256) ? 256 : c;
      @(posedge clk);
      #1 bus.cfg_cnt_we = 1'b0;
   endtask

   task automatic start_query(input logic [14:0] d, input bit with_cfg,
                              input logic [14:0] c_care, input logic [1:0] c_ch);
      logic [3:0] em;
      int         ek;
      @(negedge clk);
      chk("q_ready_idle", 32'(bus.q_ready), 32'd1);
      chk("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
      bus.q_valid = 1'b1;
      bus.q_data  = d;
      if (with_cfg) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_addr = 8'd0;
         bus.cfg_care = c_care;
         bus.cfg_val  = 15'h0;
         bus.cfg_ch   = c_ch;
         m_care[0] = c_care;
         m_val[0]  = 15'h0;
         m_ch[0]   = c_ch;
      end
      model_eval(d, em, ek);
      exp_mask_q.push_back(em);
      exp_k_q.push_back(ek);
      @(posedge clk);
      #1;
      bus.q_valid = 1'b0;
      bus.cfg_we  = 1'b0;
      chk("q_ready_busy", 32'(bus.q_ready), 32'd0);
   endtask

   task automatic finish_query(input int hold, input bit bp_cfg,
                               output logic [3:0] m, output int k);
      logic [3:0] em;
      int         ek;
      int         n;
      n = 0;
      while (!bus.res_valid && n < 400) begin
         @(posedge clk);
         #1 n++;
      end
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      em = '0;
      ek = -1;
      if (exp_mask_q.size() > 0) begin
         em = exp_mask_q.pop_front();
         ek = exp_k_q.pop_front();
      end else begin
         chk("sb_empty", 32'd0, 32'd1);
      end
      chk("latency", n, ek);
      chk("mask", 32'(bus.res_mask), 32'(em));
      m = bus.res_mask;
      k = n;
      for (int i = 0; i < hold; i++) begin
         if (bp_cfg && i == 2) begin
            bus.cfg_we     = 1'b1;
            bus.cfg_addr   = 8'd0;
            bus.cfg_care   = 15'h0;
            bus.cfg_val    = 15'h0;
            bus.cfg_ch     = 2'd3;
            bus.cfg_cnt_we = 1'b1;
            bus.cfg_cnt    = 9'd0;
         end
         @(posedge clk);
         #1;
         bus.cfg_we     = 1'b0;
         bus.cfg_cnt_we = 1'b0;
         chk("bp_mask", 32'(bus.res_mask), 32'(m));
         chk("bp_q_ready", 32'(bus.q_ready), 32'd0);
         chk("bp_cfg_ready", 32'(bus.cfg_ready), 32'd0);
         chk("bp_valid", 32'(bus.res_valid), 32'd1);
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      chk("q_ready_after", 32'(bus.q_ready), 32'd1);
      chk("res_valid_after", 32'(bus.res_valid), 32'd0);
      chk("mask_hold", 32'(bus.res_mask), 32'(m));
   endtask

   task automatic query(input logic [14:0] d, output logic [3:0] m, output int k);
      start_query(d, 1'b0, 15'h0, 2'd0);
      finish_query(0, 1'b0, m, k);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  m;
      int          k;
      logic [14:0] q;

      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_val = '0;
      bus.cfg_ch = '0; bus.cfg_cnt_we = 1'b0; bus.cfg_cnt = '0;
      bus.q_valid = 1'b0; bus.q_data = '0; bus.res_ready = 1'b0;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q_ready", 32'(bus.q_ready), 32'd1);
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_mask", 32'(bus.res_mask), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Empty table: result on the cycle after acceptance
      query(15'h1234, m, k);
      chk("empty_mask", 32'(m), 32'h0);
      chk("empty_k", k, 32'd0);

      write_term(0, 15'h7FFF, 15'h1234, 2'd0);
      write_cnt(1);
      query(15'h1234, m, k);
      chk("t0_hit_mask", 32'(m), 32'h1);
      chk("t0_hit_k", k, 32'd1);
      query(15'h1235, m, k);
      chk("t0_miss_mask", 32'(m), 32'h0);

      // Early exit once every channel is set
      for (int i = 0; i < 4; i++) write_term(i, 15'h0, 15'h0, 2'(i));
      write_cnt(8);
      query(15'h5A5A, m, k);
      chk("early_mask", 32'(m), 32'hF);
      chk("early_k", k, 32'd4);

      // chk50 cube on channel 2 versus golden equation
      write_term(0, 15'h7B90, 15'h3A00, 2'd2);
      write_cnt(1);
      for (int v = 0; v < 256; v++) begin
         for (int r = 0; r < 4; r++) begin
            q = 15'($urandom);
            q[14] = v[7]; q[13] = v[6]; q[12] = v[5]; q[11] = v[4];
            q[9]  = v[3]; q[8]  = v[2]; q[7]  = v[1]; q[4]  = v[0];
            query(q, m, k);
            chk("chk50", 32'(m[2]), 32'(g50(q)));
         end
      end

      // Backpressure with dropped config writes
      start_query(15'h3A00, 1'b0, 15'h0, 2'd0);
      finish_query(10, 1'b1, m, k);
      chk("bp_result", 32'(m), 32'h4);
      query(15'h3A00, m, k);
      chk("bp_readback_mask", 32'(m), 32'h4);
      chk("bp_readback_k", k, 32'd1);

      // Config write in the accept cycle is seen by the scan
      start_query(15'h0000, 1'b1, 15'h0, 2'd1);
      finish_query(0, 1'b0, m, k);
      chk("same_cycle_mask", 32'(m), 32'h2);

      // Full-depth scan with saturated count
      for (int i = 0; i < 255; i++) write_term(i, 15'h7FFF, 15'h0, 2'd0);
      write_term(255, 15'h0, 15'h0, 2'd3);
      write_cnt(300);
      query(15'h1234, m, k);
      chk("sat_mask", 32'(m), 32'h8);
      chk("sat_k", k, 32'd256);

      // Reset during a long scan
      write_cnt(200);
      start_query(15'h1234, 1'b0, 15'h0, 2'd0);
      repeat (50) @(posedge clk);
      #1 chk("mid_scan_valid", 32'(bus.res_valid), 32'd0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_mid_q_ready", 32'(bus.q_ready), 32'd1);
      chk("rst_mid_mask", 32'(bus.res_mask), 32'd0);
      exp_mask_q.delete();
      exp_k_q.delete();
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      query(15'h1234, m, k);
      chk("post_rst_mask", 32'(m), 32'h0);
      chk("post_rst_k", k, 32'd0);
      write_cnt(1);
      query(15'h1234, m, k);
      chk("post_rst_cleared_tbl", 32'(m), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prm_oblgc_scan.md
# prm_oblgc_scan

Programmable, sequential successor to the fixed `prm_oblgc_chk*` obstacle-logic checkers. It stores the sum-of-products terms for up to `NUM_CH` obstacle checks in a writable term table. It evaluates one quantised C-space query against those terms, one term per cycle, and returns a per-channel `edge_mask`. It sits between the PRM edge sampler (query producer) and the roadmap edge-pruning logic (mask consumer). Term tables can be reloaded without re-synthesis.

## Interface
Parameters:
- `IN_W`, 15, query width; bit 0 = A … bit 14 = O.
- `NUM_TERMS`, 256, term-table depth.
- `NUM_CH`, 4, number of independent obstacle checks (mask bits).
- `TA_W`, `$clog2(NUM_TERMS)`, term address width.
- `CH_W`, `$clog2(NUM_CH)` (min 1), channel index width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RSTn` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: write one term.
- `cfg_addr` in `TA_W`: term index.
- `cfg_care` in `IN_W`: literal-present mask.
- `cfg_val` in `IN_W`: literal polarity (1 = true literal).
- `cfg_ch` in `CH_W`: channel the term ORs into.
- `cfg_cnt_we` in 1: write the active term count.
- `cfg_cnt` in `TA_W+1`: active terms, 0..`NUM_TERMS`.
- `cfg_ready` out 1: config writes accepted (IDLE only).
- `q_valid` in 1: query valid.
- `q_data` in `IN_W`: query vector.
- `q_ready` out 1: query accepted.
- `res_valid` out 1: result valid.
- `res_mask` out `NUM_CH`: per-channel edge_mask.
- `res_ready` in 1: consumer accepts result.

## Operation
- Term match: a term hits when `((q ^ val) & care) == 0`. A term with `care = 0` matches every query.
- Channel result: the OR of all hitting terms with `ch` = that channel, taken over indices 0..`term_cnt-1`.
- Terms with `ch >= NUM_CH` are ignored.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `q_ready = cfg_ready = 1`.
  - On `q_valid`: capture `q_data`, clear the mask, set `idx = 0`.
  - Go to DONE if `term_cnt == 0`, else to SCAN.
- SCAN:
  - Each cycle, evaluate `term[idx]` and OR its hit into the mask.
  - Go to DONE after `idx == term_cnt-1`, or early once the updated mask is all ones.
  - Otherwise increment `idx`.
- DONE:
  - `res_valid = 1`; `res_mask` is held stable.
  - On `res_ready`, go to IDLE.
- Config writes outside IDLE are dropped, with no effect. `cfg_we` and `cfg_cnt_we` may be asserted together in the same cycle.
- A `cfg_cnt` value above `NUM_TERMS` is saturated to `NUM_TERMS`.
- Query and config in the same IDLE cycle: the config write commits, and the scan uses the updated table from its first SCAN cycle.

## Timing
- Reset values:
  - State = IDLE.
  - `term_cnt = 0`; term table care/val/ch = 0.
  - `q_ready = 1`, `cfg_ready = 1`.
  - `res_valid = 0`, `res_mask = 0`.
- Latency: query accepted in cycle T → `res_valid` rises at T+1+k, where k = terms evaluated (k = 0 if `term_cnt == 0`; k ≤ `term_cnt`).
- One query in flight at a time. `q_ready` is low from T+1 until the cycle after the DONE handshake.
- Back-to-back throughput: a new query is accepted no earlier than the cycle after `res_valid && res_ready`.
- `res_mask` holds its value after the handshake until the next accepted query clears it.
- Reset asserted mid-SCAN or mid-DONE: immediate return to reset values. The partial result is discarded and the term table is cleared.

## Structure
- `prm_oblgc_pkg` holds:
  - the state enum (`IDLE`, `SCAN`, `DONE`);
  - the `term_t` struct {care, val, ch}, built from the package defaults of `IN_W`/`CH_W`;
  - the localparam all-ones mask helper.
- Sub-module `prm_oblgc_term_match`: combinational cube match (query, care, val → hit). It is reused by the future parallel-lane variant.
- Term table is a register array with a combinational read; no SRAM macro at default depth.

## Test plan
- Reset, then a query with `q_data = 0x1234` and `term_cnt = 0` → `res_valid` at T+1, `res_mask = 4'b0000`.
- Term0 {care = 0x7FFF, val = 0x1234, ch = 0}, `cnt = 1`; query 0x1234 → mask 0001 at T+2. Query 0x1235 → mask 0000.
- Terms 0..3 all `care = 0`, ch 0..3, `cnt = 8` → early exit after 4 terms: `res_valid` at T+5, mask 1111.
- Load one term from the `prm_oblgc_chk50` equations, e.g. (!O&N&M&L&J&!I&!H&!E) on ch 2. Compare `res_mask[2]` against the golden `edge_mask` for all 2^15 queries; the two must agree.
- Backpressure: hold `res_ready = 0` for 10 cycles → `res_mask` stable, `q_ready = 0`, and `cfg_we` pulses have no effect on a subsequent readback.
- Assert `RSTn` low in the middle of a 200-term scan → `res_valid` low, state IDLE, `term_cnt = 0`; the next query returns 0000.
